// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the DLX ID/EX issue stage (the myTypes definitions).
//   aluoptype     : ALU operation encoding; OP_NOP is the side-effect-free bubble op.
//   ex_ctrl_t     : control bundle captured into the EX stage.
//   EX_CTRL_BUBBLE: control value loaded when a bubble is inserted.
package alu_issue_stage_pkg;

  localparam int unsigned NBIT_DEF      = 32;
  localparam int unsigned NREG_ADDR_DEF = 5;
  localparam int unsigned ALU_OP_W      = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8,
    OP_SLT = 4'd9,
    OP_SGT = 4'd10,
    OP_SLE = 4'd11,
    OP_SGE = 4'd12,
    OP_SEQ = 4'd13,
    OP_SNE = 4'd14
  } aluoptype;

  typedef struct packed {
    aluoptype                 alu_op;
    logic [NREG_ADDR_DEF-1:0] rd_addr;
    logic                     rd_we;
    logic                     is_load;
    logic                     sel_imm;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    alu_op:  OP_NOP,
    rd_addr: '0,
    rd_we:   1'b0,
    is_load: 1'b0,
    sel_imm: 1'b0
  };

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Operand forwarding mux for one ALU source.
//   src_addr/reg_data       : source register index and its registered value.
//   exmem_* / memwb_*       : forwarding tuples (rd_addr, rd_we, result).
//   fwd_data_c              : forwarded operand (combinational).
// EX/MEM wins over MEM/WB; r0 is never forwarded.
module alu_fwd_mux #(
  parameter int unsigned NBIT      = 32,
  parameter int unsigned NREG_ADDR = 5
) (
  input  logic [NREG_ADDR-1:0] src_addr,
  input  logic [NBIT-1:0]      reg_data,
  input  logic [NREG_ADDR-1:0] exmem_rd_addr,
  input  logic                 exmem_rd_we,
  input  logic [NBIT-1:0]      exmem_result,
  input  logic [NREG_ADDR-1:0] memwb_rd_addr,
  input  logic                 memwb_rd_we,
  input  logic [NBIT-1:0]      memwb_result,
  output logic [NBIT-1:0]      fwd_data_c
);

  logic src_nonzero;
  logic hit_exmem;
  logic hit_memwb;

  assign src_nonzero = (src_addr != '0);
  assign hit_exmem   = exmem_rd_we && (exmem_rd_addr == src_addr) && src_nonzero;
  assign hit_memwb   = memwb_rd_we && (memwb_rd_addr == src_addr) && src_nonzero;

  // Priority select: youngest producer first.
  always_comb begin
    fwd_data_c = reg_data;
    if (hit_exmem) begin
      fwd_data_c = exmem_result;
    end else if (hit_memwb) begin
      fwd_data_c = memwb_result;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU, with RAW forwarding and
// load-use hazard detection.
//   Inputs : id_* decoded instruction, exmem_*/memwb_* forwarding sources,
//            stall_in (hold), flush (squash to bubble).
//   Outputs: id_stall (load-use, combinational), ex_valid, alu_op,
//            alu_in_a/alu_in_b (combinational, forwarded), ex_rd_addr,
//            ex_rd_we, ex_is_load.
// NREG_ADDR must equal the package register-address width used in ex_ctrl_t.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned NBIT      = NBIT_DEF,
  parameter int unsigned NREG_ADDR = NREG_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  aluoptype             id_alu_op,
  input  logic [NREG_ADDR-1:0] id_rs1_addr,
  input  logic [NREG_ADDR-1:0] id_rs2_addr,
  input  logic [NBIT-1:0]      id_rs1_data,
  input  logic [NBIT-1:0]      id_rs2_data,
  input  logic [NBIT-1:0]      id_imm,
  input  logic                 id_sel_imm,
  input  logic [NREG_ADDR-1:0] id_rd_addr,
  input  logic                 id_rd_we,
  input  logic                 id_is_load,
  input  logic [NREG_ADDR-1:0] exmem_rd_addr,
  input  logic                 exmem_rd_we,
  input  logic [NBIT-1:0]      exmem_result,
  input  logic [NREG_ADDR-1:0] memwb_rd_addr,
  input  logic                 memwb_rd_we,
  input  logic [NBIT-1:0]      memwb_result,
  input  logic                 stall_in,
  input  logic                 flush,
  output logic                 id_stall,
  output logic                 ex_valid,
  output aluoptype             alu_op,
  output logic [NBIT-1:0]      alu_in_a,
  output logic [NBIT-1:0]      alu_in_b,
  output logic [NREG_ADDR-1:0] ex_rd_addr,
  output logic                 ex_rd_we,
  output logic                 ex_is_load
);

  logic                 valid_q,    valid_d;
  ex_ctrl_t             ctrl_q,     ctrl_d;
  logic [NREG_ADDR-1:0] rs1_addr_q, rs1_addr_d;
  logic [NREG_ADDR-1:0] rs2_addr_q, rs2_addr_d;
  logic [NBIT-1:0]      rs1_data_q, rs1_data_d;
  logic [NBIT-1:0]      rs2_data_q, rs2_data_d;
  logic [NBIT-1:0]      imm_q,      imm_d;

  logic [NBIT-1:0]      fwd_a;
  logic [NBIT-1:0]      fwd_b;
  logic [NREG_ADDR-1:0] ex_rd;
  logic                 load_use;

  // Forwarded operand for source A.
  alu_fwd_mux #(.NBIT(NBIT), .NREG_ADDR(NREG_ADDR)) u_fwd_a (
    .src_addr      (rs1_addr_q),
    .reg_data      (rs1_data_q),
    .exmem_rd_addr (exmem_rd_addr),
    .exmem_rd_we   (exmem_rd_we),
    .exmem_result  (exmem_result),
    .memwb_rd_addr (memwb_rd_addr),
    .memwb_rd_we   (memwb_rd_we),
    .memwb_result  (memwb_result),
    .fwd_data_c    (fwd_a)
  );

  // Forwarded register operand for source B (before the immediate select).
  alu_fwd_mux #(.NBIT(NBIT), .NREG_ADDR(NREG_ADDR)) u_fwd_b (
    .src_addr      (rs2_addr_q),
    .reg_data      (rs2_data_q),
    .exmem_rd_addr (exmem_rd_addr),
    .exmem_rd_we   (exmem_rd_we),
    .exmem_result  (exmem_result),
    .memwb_rd_addr (memwb_rd_addr),
    .memwb_rd_we   (memwb_rd_we),
    .memwb_result  (memwb_result),
    .fwd_data_c    (fwd_b)
  );

  assign ex_rd = NREG_ADDR'(ctrl_q.rd_addr);

  // Load-use: the EX load's result is not forwardable until MEM, so the
  // dependent instruction waits one cycle. rs2 only counts when it is used.
  assign load_use = id_valid && valid_q && ctrl_q.is_load && (ex_rd != '0) &&
                    ((ex_rd == id_rs1_addr) ||
                     ((ex_rd == id_rs2_addr) && !id_sel_imm));

  assign id_stall = load_use && !flush;

  // Next-state: flush > stall_in (hold + operand refresh) > load-use bubble > load.
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = EX_CTRL_BUBBLE;
    end else if (stall_in) begin
      // Latch forwarded values so operands outlive their producers retiring.
      rs1_data_d = fwd_a;
      rs2_data_d = fwd_b;
    end else if (load_use) begin
      valid_d = 1'b0;
      ctrl_d  = EX_CTRL_BUBBLE;
    end else begin
      valid_d        = id_valid;
      ctrl_d.alu_op  = id_alu_op;
      ctrl_d.rd_addr = NREG_ADDR_DEF'(id_rd_addr);
      ctrl_d.rd_we   = id_rd_we && id_valid;
      ctrl_d.is_load = id_is_load && id_valid;
      ctrl_d.sel_imm = id_sel_imm;
      rs1_addr_d     = id_rs1_addr;
      rs2_addr_d     = id_rs2_addr;
      rs1_data_d     = id_rs1_data;
      rs2_data_d     = id_rs2_data;
      imm_d          = id_imm;
    end
  end

  // EX stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= EX_CTRL_BUBBLE;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  assign ex_valid   = valid_q;
  assign alu_op     = ctrl_q.alu_op;
  assign ex_rd_addr = ex_rd;
  assign ex_rd_we   = ctrl_q.rd_we;
  assign ex_is_load = ctrl_q.is_load;
  assign alu_in_a   = fwd_a;
  assign alu_in_b   = ctrl_q.sel_imm ? imm_q : fwd_b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic,
// checked against a cycle model of the EX stage held in plain variables.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int unsigned NBIT = 32;
  localparam int unsigned NRA  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  aluoptype        id_alu_op;
  logic [NRA-1:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [NBIT-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic            id_sel_imm, id_rd_we, id_is_load;
  logic [NRA-1:0]  exmem_rd_addr, memwb_rd_addr;
  logic            exmem_rd_we, memwb_rd_we;
  logic [NBIT-1:0] exmem_result, memwb_result;
  logic            stall_in, flush;
  logic            id_stall, ex_valid;
  aluoptype        alu_op;
  logic [NBIT-1:0] alu_in_a, alu_in_b;
  logic [NRA-1:0]  ex_rd_addr;
  logic            ex_rd_we, ex_is_load;

  int checks = 0;
  int errors = 0;

  // Reference EX-stage contents.
  logic            m_valid;
  aluoptype        m_op;
  logic [NRA-1:0]  m_rs1, m_rs2, m_rd;
  logic [NBIT-1:0] m_d1, m_d2, m_imm;
  logic            m_sel, m_we, m_ld;

  always #5 clk = ~clk;

  alu_issue_stage #(.NBIT(NBIT), .NREG_ADDR(NRA)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_sel_imm(id_sel_imm),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .exmem_rd_addr(exmem_rd_addr), .exmem_rd_we(exmem_rd_we), .exmem_result(exmem_result),
    .memwb_rd_addr(memwb_rd_addr), .memwb_rd_we(memwb_rd_we), .memwb_result(memwb_result),
    .stall_in(stall_in), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .alu_op(alu_op),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NBIT-1:0] fwd(input logic [NRA-1:0] a, input logic [NBIT-1:0] d);
    if (a == 0) return d;
    if (exmem_rd_we && exmem_rd_addr == a) return exmem_result;
    if (memwb_rd_we && memwb_rd_addr == a) return memwb_result;
    return d;
  endfunction

  function automatic logic exp_stall();
    logic dep;
    dep = (m_rd == id_rs1_addr) || (m_rd == id_rs2_addr && !id_sel_imm);
    return !flush && id_valid && m_valid && m_ld && m_rd != 0 && dep;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op = OP_NOP; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_sel = 0; m_we = 0; m_ld = 0;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_alu_op = OP_NOP; id_rs1_addr = 0; id_rs2_addr = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_sel_imm = 0;
    id_rd_addr = 0; id_rd_we = 0; id_is_load = 0;
    exmem_rd_addr = 0; exmem_rd_we = 0; exmem_result = 0;
    memwb_rd_addr = 0; memwb_rd_we = 0; memwb_result = 0;
    stall_in = 0; flush = 0;
  endtask

  task automatic set_id(input aluoptype op, input int r1, input int d1, input int r2,
                        input int d2, input logic sel, input int imm, input int rd,
                        input logic we, input logic ld);
    id_valid = 1; id_alu_op = op;
    id_rs1_addr = NRA'(r1); id_rs1_data = NBIT'(d1);
    id_rs2_addr = NRA'(r2); id_rs2_data = NBIT'(d2);
    id_sel_imm = sel; id_imm = NBIT'(imm);
    id_rd_addr = NRA'(rd); id_rd_we = we; id_is_load = ld;
  endtask

  // Compare every observable output with the model; operands and rd only matter
  // for a real instruction.
  task automatic check_cycle();
    check("id_stall", 64'(id_stall), 64'(exp_stall()));
    check("ex_valid", 64'(ex_valid), 64'(m_valid));
    check("ex_rd_we", 64'(ex_rd_we), 64'(m_we));
    check("ex_is_load", 64'(ex_is_load), 64'(m_ld));
    check("alu_op", 64'(alu_op), 64'(m_op));
    if (m_valid) begin
      check("ex_rd_addr", 64'(ex_rd_addr), 64'(m_rd));
      check("alu_in_a", 64'(alu_in_a), 64'(fwd(m_rs1, m_d1)));
      check("alu_in_b", 64'(alu_in_b), 64'(m_sel ? m_imm : fwd(m_rs2, m_d2)));
    end
  endtask

  // Check, then advance model and DUT by one clock; returns at the next negedge.
  task automatic tick();
    logic            bubble, load;
    logic [NBIT-1:0] n1, n2;
    #1;
    check_cycle();
    bubble = flush || (!stall_in && exp_stall());
    load   = !flush && !stall_in && !exp_stall();
    n1 = fwd(m_rs1, m_d1);
    n2 = fwd(m_rs2, m_d2);
    @(posedge clk);
    if (bubble) begin
      m_valid = 0; m_we = 0; m_ld = 0; m_op = OP_NOP;
    end else if (stall_in) begin
      m_d1 = n1; m_d2 = n2;
    end else if (load) begin
      m_valid = id_valid; m_op = id_alu_op;
      m_rs1 = id_rs1_addr; m_rs2 = id_rs2_addr;
      m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_sel = id_sel_imm;
      m_rd = id_rd_addr; m_we = id_rd_we && id_valid; m_ld = id_is_load && id_valid;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ex_valid"}, 64'(ex_valid), 64'd0);
    check({tag, ".alu_op"}, 64'(alu_op), 64'(OP_NOP));
    check({tag, ".alu_in_a"}, 64'(alu_in_a), 64'd0);
    check({tag, ".alu_in_b"}, 64'(alu_in_b), 64'd0);
    check({tag, ".ex_rd_we"}, 64'(ex_rd_we), 64'd0);
    check({tag, ".ex_is_load"}, 64'(ex_is_load), 64'd0);
    check({tag, ".ex_rd_addr"}, 64'(ex_rd_addr), 64'd0);
    check({tag, ".id_stall"}, 64'(id_stall), 64'd0);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;

    // Plain ADD r1=5, r2=7.
    set_id(OP_ADD, 1, 5, 2, 7, 0, 0, 5, 1, 0);
    tick();
    clear_inputs();
    #1;
    check("add.valid", 64'(ex_valid), 64'd1);
    check("add.a", 64'(alu_in_a), 64'd5);
    check("add.b", 64'(alu_in_b), 64'd7);
    tick();

    // EX/MEM beats MEM/WB, then MEM/WB alone.
    set_id(OP_OR, 3, 32'h99, 0, 0, 0, 0, 6, 1, 0);
    tick();
    clear_inputs();
    exmem_rd_addr = 3; exmem_rd_we = 1; exmem_result = 32'h10;
    memwb_rd_addr = 3; memwb_rd_we = 1; memwb_result = 32'h20;
    #1;
    check("fwd.exmem", 64'(alu_in_a), 64'h10);
    exmem_rd_we = 0;
    #1;
    check("fwd.memwb", 64'(alu_in_a), 64'h20);
    tick();
    clear_inputs();

    // Load-use on rs2 (register operand) stalls and bubbles.
    set_id(OP_ADD, 0, 0, 0, 0, 0, 0, 4, 1, 1);
    tick();
    set_id(OP_SUB, 1, 1, 4, 2, 0, 0, 7, 1, 0);
    #1;
    check("lu.stall", 64'(id_stall), 64'd1);
    tick();
    clear_inputs();
    #1;
    check("lu.bubble_valid", 64'(ex_valid), 64'd0);
    check("lu.bubble_op", 64'(alu_op), 64'(OP_NOP));
    tick();

    // Same dependency through rs2 but B is the immediate: no stall.
    set_id(OP_ADD, 0, 0, 0, 0, 0, 0, 4, 1, 1);
    tick();
    set_id(OP_ADD, 1, 1, 4, 2, 1, 9, 7, 1, 0);
    #1;
    check("lu.imm_nostall", 64'(id_stall), 64'd0);
    tick();
    clear_inputs();

    // r0 is never forwarded.
    set_id(OP_ADD, 0, 0, 0, 0, 1, 3, 8, 1, 0);
    tick();
    clear_inputs();
    exmem_rd_addr = 0; exmem_rd_we = 1; exmem_result = 32'hFF;
    #1;
    check("r0.a", 64'(alu_in_a), 64'd0);
    tick();
    clear_inputs();

    // Downstream stall: forwarded 0x33 is kept after EX/MEM retires.
    set_id(OP_ADD, 6, 1, 0, 0, 1, 4, 9, 1, 0);
    tick();
    set_id(OP_XOR, 7, 32'h77, 8, 32'h88, 0, 0, 10, 1, 0);
    stall_in = 1;
    exmem_rd_addr = 6; exmem_rd_we = 1; exmem_result = 32'h33;
    #1;
    check("stall.c1", 64'(alu_in_a), 64'h33);
    tick();
    exmem_rd_we = 0;
    #1;
    check("stall.c2", 64'(alu_in_a), 64'h33);
    tick();
    #1;
    check("stall.c3", 64'(alu_in_a), 64'h33);
    check("stall.op", 64'(alu_op), 64'(OP_ADD));
    tick();
    clear_inputs();
    #1;
    check("stall.after", 64'(alu_in_a), 64'h33);
    tick();

    // Flush beats stall_in and the load-use hazard.
    set_id(OP_ADD, 0, 0, 0, 0, 0, 0, 4, 1, 1);
    tick();
    set_id(OP_ADD, 4, 0, 0, 0, 1, 0, 11, 1, 0);
    stall_in = 1; flush = 1;
    #1;
    check("flush.stall", 64'(id_stall), 64'd0);
    tick();
    clear_inputs();
    #1;
    check("flush.valid", 64'(ex_valid), 64'd0);
    check("flush.rd_we", 64'(ex_rd_we), 64'd0);
    check("flush.id_stall", 64'(id_stall), 64'd0);
    tick();

    // Asynchronous reset mid-instruction.
    set_id(OP_SUB, 2, 32'h1234, 3, 32'h5678, 0, 0, 12, 1, 1);
    tick();
    clear_inputs();
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic with a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      id_valid      = ($urandom_range(0, 7) != 0);
      id_alu_op     = aluoptype'(ALU_OP_W'($urandom_range(0, 14)));
      id_rs1_addr   = NRA'($urandom_range(0, 3));
      id_rs2_addr   = NRA'($urandom_range(0, 3));
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_imm        = $urandom;
      id_sel_imm    = $urandom_range(0, 1) != 0;
      id_rd_addr    = NRA'($urandom_range(0, 3));
      id_rd_we      = $urandom_range(0, 3) != 0;
      id_is_load    = $urandom_range(0, 2) == 0;
      exmem_rd_addr = NRA'($urandom_range(0, 3));
      exmem_rd_we   = $urandom_range(0, 1) != 0;
      exmem_result  = $urandom;
      memwb_rd_addr = NRA'($urandom_range(0, 3));
      memwb_rd_we   = $urandom_range(0, 1) != 0;
      memwb_result  = $urandom;
      stall_in      = $urandom_range(0, 5) == 0;
      flush         = $urandom_range(0, 15) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
